unpack_s3_byte_seq: RTL and testbench

Byte-sequencing controller for the S3 (ternary) unpack path of the NTRU-HRSS KEM. It accepts packed polynomial data as 32-bit words and drives the 4:1 byte-select. It emits one byte per handshake to the downstream byte-to-trits decoder until exactly NBYTES bytes have been delivered, then flags completion. It sits between the word source (memory or bus) and the trit decoder.

---
 rtl/unpack_s3_byte_seq_if.sv | 28 ++
 rtl/unpack_s3_byte_seq.sv | 104 ++++++++++
 tb/tb_unpack_s3_byte_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/unpack_s3_byte_seq_if.sv
// rtl/unpack_s3_byte_seq_if.sv - word-in / byte-out handshake bundle for the S3 unpack byte sequencer
interface unpack_s3_byte_seq_if #(
   parameter int CW = 8
);
   logic          start;
   logic          abort;
   logic [31:0]   word_in;
   logic          word_valid;
   logic          word_ready;
   logic [1:0]    sel;
   logic [7:0]    byte_out;
   logic          byte_valid;
   logic          byte_ready;
   logic          byte_last;
   logic [CW-1:0] byte_cnt;
   logic          busy;
   logic          done;

   modport master (
      output start, abort, word_in, word_valid, byte_ready,
      input  word_ready, sel, byte_out, byte_valid, byte_last, byte_cnt, busy, done
   );

   modport slave (
      input  start, abort, word_in, word_valid, byte_ready,
      output word_ready, sel, byte_out, byte_valid, byte_last, byte_cnt, busy, done
   );
endinterface

// File: rtl/unpack_s3_byte_seq.sv
// rtl/unpack_s3_byte_seq.sv - S3 unpack byte sequencer: 32-bit words in, one byte per handshake out
module unpack_s3_byte_seq #(
   parameter int NBYTES = 140,
   parameter int CW     = $clog2(NBYTES + 1)
) (
   input logic                 clk,
   input logic                 rst,
   unpack_s3_byte_seq_if.slave bus
);
   typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

   state_t        state;
   state_t        state_nx;
   logic [31:0]   held_word;
   logic [1:0]    sel;
   logic [CW-1:0] byte_cnt;
   logic          is_last;

   assign is_last = (byte_cnt == CW'(NBYTES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (bus.abort) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:    if (bus.start) state_nx = FETCH;
            FETCH:   if (bus.word_valid) state_nx = EMIT;
            EMIT: begin
               if (bus.byte_ready) begin
                  if (is_last)           state_nx = DONE;
                  else if (sel == 2'd3)  state_nx = FETCH;
               end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Byte index stays frozen on the final byte so a partial last word never advances past it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held_word <= 32'h0;
         sel       <= 2'd0;
         byte_cnt  <= '0;
      end else if (bus.abort) begin
         sel      <= 2'd0;
         byte_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) byte_cnt <= '0;
            end
            FETCH: begin
               if (bus.word_valid) begin
                  held_word <= bus.word_in;
                  sel       <= 2'd0;
               end
            end
            EMIT: begin
               if (bus.byte_ready) begin
                  byte_cnt <= byte_cnt + CW'(1);
                  if (!is_last && sel != 2'd3) sel <= sel + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.word_ready = 1'b0;
      bus.byte_valid = 1'b0;
      bus.byte_last  = 1'b0;
      bus.busy       = 1'b0;
      bus.done       = 1'b0;
      case (state)
         FETCH: begin
            bus.word_ready = 1'b1;
            bus.busy       = 1'b1;
         end
         EMIT: begin
            bus.byte_valid = 1'b1;
            bus.byte_last  = is_last;
            bus.busy       = 1'b1;
         end
         DONE: begin
            bus.done = 1'b1;
            bus.busy = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.sel      = sel;
   assign bus.byte_cnt = byte_cnt;
   assign bus.byte_out = held_word[{sel, 3'b000} +: 8];
endmodule

// File: tb/tb_unpack_s3_byte_seq.sv
// tb/tb_unpack_s3_byte_seq.sv - scoreboard bench for unpack_s3_byte_seq with NBYTES = 8, 6 and 140
module tb_unpack_s3_byte_seq;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [2:0]  start_v;
   logic        abort_v;
   logic [31:0] word_v;
   logic        wvalid_v;
   logic        bready_v;

   unpack_s3_byte_seq_if #(.CW(4)) if0 ();
   unpack_s3_byte_seq_if #(.CW(3)) if1 ();
   unpack_s3_byte_seq_if #(.CW(8)) if2 ();

   unpack_s3_byte_seq #(.NBYTES(8))   dut0 (.clk(clk), .rst(rst), .bus(if0));
   unpack_s3_byte_seq #(.NBYTES(6))   dut1 (.clk(clk), .rst(rst), .bus(if1));
   unpack_s3_byte_seq #(.NBYTES(140)) dut2 (.clk(clk), .rst(rst), .bus(if2));

   assign if0.start = start_v[0];
   assign if1.start = start_v[1];
   assign if2.start = start_v[2];
   assign if0.abort = abort_v;
   assign if1.abort = abort_v;
   assign if2.abort = abort_v;
   assign if0.word_in = word_v;
   assign if1.word_in = word_v;
   assign if2.word_in = word_v;
   assign if0.word_valid = wvalid_v;
   assign if1.word_valid = wvalid_v;
   assign if2.word_valid = wvalid_v;
   assign if0.byte_ready = bready_v;
   assign if1.byte_ready = bready_v;
   assign if2.byte_ready = bready_v;

   int         dsel;
   logic       o_wready, o_bvalid, o_blast, o_busy, o_done;
   logic [1:0] o_sel;
   logic [7:0] o_byte, o_cnt;

   always_comb begin
      o_wready = if2.word_ready; o_bvalid = if2.byte_valid; o_blast = if2.byte_last;
      o_busy   = if2.busy;       o_done   = if2.done;       o_sel   = if2.sel;
      o_byte   = if2.byte_out;   o_cnt    = if2.byte_cnt;
      if (dsel == 0) begin
         o_wready = if0.word_ready; o_bvalid = if0.byte_valid; o_blast = if0.byte_last;
         o_busy   = if0.busy;       o_done   = if0.done;       o_sel   = if0.sel;
         o_byte   = if0.byte_out;   o_cnt    = {4'b0, if0.byte_cnt};
      end else if (dsel == 1) begin
         o_wready = if1.word_ready; o_bvalid = if1.byte_valid; o_blast = if1.byte_last;
         o_busy   = if1.busy;       o_done   = if1.done;       o_sel   = if1.sel;
         o_byte   = if1.byte_out;   o_cnt    = {5'b0, if1.byte_cnt};
      end
   end

   logic [7:0]  exp_q[$];
   logic [31:0] words[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One polynomial on DUT idx. hold_at/abort_at are byte indices (-1 = off); dup_start_at is a cycle offset.
   task automatic run(input int idx, input int n, input int stall_pct, input int hold_at,
                      input int abort_at, input int dup_start_at);
      int  wi = 0, nw = 0, nb = 0, nd = 0, nwr = 0, it = 0, pushed = 0, held = 0, done_it = -1, dn = 0;
      int  nwords;
      bit  fin = 0;
      logic [7:0] e;
      nwords = (n + 3) / 4;
      dsel = idx;
      exp_q.delete();
      @(negedge clk);
      start_v[idx] = 1'b1;
      while (!fin && it < 3000) begin
         @(negedge clk);
         it++;
         start_v = '0;
         abort_v = 1'b0;
         if (it == dup_start_at) start_v[idx] = 1'b1;
         wvalid_v = (wi < words.size()) && ($urandom_range(99) >= stall_pct);
         word_v   = (wi < words.size()) ? words[wi] : 32'hDEAD_BEEF;
         bready_v = ($urandom_range(99) >= stall_pct);
         nwr += int'(o_wready);
         if (o_bvalid && int'(o_cnt) == hold_at && held < 3) begin
            bready_v = 1'b0;
            held++;
            check("hold_byte", o_byte, 8'hBB);
            check("hold_sel", o_sel, 2'd1);
            check("hold_cnt", o_cnt, 8'd1);
         end
         if (o_done) begin
            nd++;
            done_it = it;
            check("done_cnt", o_cnt, n);
            check("done_busy", o_busy, 1'b1);
            fin = 1;
            wvalid_v = 1'b0;
            bready_v = 1'b0;
         end
         if (o_wready && wvalid_v) begin
            for (int k = 0; k < 4; k++) begin
               if (pushed < n) begin
                  exp_q.push_back(words[wi][8*k +: 8]);
                  pushed++;
               end
            end
            wi++;
            nw++;
         end
         if (o_bvalid && bready_v) begin
            check("byte_cnt", o_cnt, nb);
            check("byte_last", o_blast, (nb == n - 1));
            if (exp_q.size() == 0) begin
               check("byte_underflow", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("byte_data", o_byte, e);
            end
            if (nb == abort_at) begin
               abort_v = 1'b1;
               fin = 1;
            end
            nb++;
         end
      end
      check("run_finished", fin, 1'b1);
      if (abort_at >= 0) begin
         @(negedge clk);
         abort_v  = 1'b0;
         bready_v = 1'b0;
         wvalid_v = 1'b0;
         check("abort_busy", o_busy, 1'b0);
         check("abort_cnt", o_cnt, 8'd0);
         check("abort_bvalid", o_bvalid, 1'b0);
         check("abort_sel", o_sel, 2'd0);
         repeat (5) begin
            dn += int'(o_done);
            @(negedge clk);
         end
         check("abort_no_done", dn, 0);
      end else begin
         check("done_pulses", nd, 1);
         check("byte_xfers", nb, n);
         check("word_xfers", nw, nwords);
         check("queue_drained", exp_q.size(), 0);
         if (stall_pct == 0 && hold_at < 0) begin
            check("done_latency", done_it, n + nwords + 1);
            check("word_ready_cycles", nwr, nwords);
         end
         @(negedge clk);
         check("post_done_busy", o_busy, 1'b0);
         check("post_done_done", o_done, 1'b0);
         check("post_done_cnt", o_cnt, n);
      end
   endtask

   initial begin
      rst      = 1'b1;
      start_v  = '0;
      abort_v  = 1'b0;
      word_v   = 32'h0;
      wvalid_v = 1'b0;
      bready_v = 1'b0;
      dsel     = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_word_ready", o_wready, 1'b0);
      check("rst_byte_valid", o_bvalid, 1'b0);
      check("rst_byte_last", o_blast, 1'b0);
      check("rst_byte_out", o_byte, 8'h00);
      check("rst_sel", o_sel, 2'd0);
      check("rst_cnt", o_cnt, 8'd0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_done", o_done, 1'b0);

      // Asynchronous reset while a byte is being presented.
      words = {32'h4433_2211, 32'h8877_6655};
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v  = '0;
      word_v   = words[0];
      wvalid_v = 1'b1;
      @(negedge clk);
      wvalid_v = 1'b0;
      check("pre_rst_bvalid", o_bvalid, 1'b1);
      check("pre_rst_byte", o_byte, 8'h11);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", o_busy, 1'b0);
      check("async_rst_bvalid", o_bvalid, 1'b0);
      check("async_rst_byte", o_byte, 8'h00);
      check("async_rst_cnt", o_cnt, 8'd0);
      check("async_rst_wready", o_wready, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      run(0, 8, 0, -1, -1, -1);

      words = {32'hDDCC_BBAA, 32'h4433_2211};
      run(1, 6, 0, -1, -1, -1);

      words = {32'hDDCC_BBAA, 32'h8877_6655};
      run(0, 8, 0, 1, -1, -1);

      words = {32'h4433_2211, 32'h8877_6655};
      run(0, 8, 0, -1, 2, -1);

      run(0, 8, 0, -1, -1, 4);

      words.delete();
      for (int i = 0; i < 35; i++) words.push_back($urandom);
      run(2, 140, 30, -1, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
